// File: rtl/spi_slave_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_io_pkg
//  Description : Shared constants for the Beta SPI responder. This covers the
//                status bit positions, the control field positions, the FSM
//                state encoding and small width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_io_pkg;

    // Status word bit positions
    localparam int c_STAT_RX_VALID = 0;
    localparam int c_STAT_BUSY     = 1;
    localparam int c_STAT_OVERRUN  = 2;
    localparam int c_STAT_TX_STALE = 3;

    // Control word fields
    localparam int c_CTRL_WIDTH_LSB = 0;
    localparam int c_CTRL_WIDTH_MSB = 4;
    localparam int c_CTRL_ENABLE    = 8;

    // FSM state encoding
    localparam logic [2:0] c_ST_OFF   = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_START = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // A programmed width of zero still moves one bit per frame
    function automatic logic [4:0] eff_width(input logic [4:0] raw);
        return (raw == 5'd0) ? 5'd1 : raw;
    endfunction

    // Right-justified mask with the low w bits set (w is at most 31)
    function automatic logic [31:0] width_mask(input logic [4:0] w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Two-flop synchronizer for one asynchronous SPI pin. A third
//                register provides one-cycle rise/fall strobes on the
//                synchronized level.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);
    import spi_slave_io_pkg::*;

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus the delayed copy used for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync = r_sync;
    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_io.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_io
//  Description : Memory-mapped SPI mode-0 responder for the Beta I/O bus.
//                It oversamples sclk/mosi/cs_n and shifts a run-time
//                programmable word (1..31 bits) MSB-first in both directions.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_io (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ctrl_reg,
    input  logic [31:0] din,
    input  logic        load,
    input  logic        ack,
    output logic [31:0] dout,
    output logic [31:0] status_reg,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs_n,
    output logic        miso
);
    import spi_slave_io_pkg::*;

    localparam int c_PIN_SCLK = 0;
    localparam int c_PIN_MOSI = 1;
    localparam int c_PIN_CS   = 2;
    localparam int c_NUM_PINS = 3;

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic [c_NUM_PINS-1:0] w_pins;
    logic [c_NUM_PINS-1:0] w_pin_sync;
    logic [c_NUM_PINS-1:0] w_pin_rise;
    logic [c_NUM_PINS-1:0] w_pin_fall;

    assign w_pins = {cs_n, mosi, sclk};

    // cs_n comes out of reset deasserted so that no frame starts on reset release
    generate
        for (genvar i = 0; i < c_NUM_PINS; i++) begin : g_pin_sync
            spi_pin_sync #(
                .RESET_VAL (i == c_PIN_CS)
            ) u_pin_sync (
                .clk   (clk),
                .reset (reset),
                .pin   (w_pins[i]),
                .sync  (w_pin_sync[i]),
                .rise  (w_pin_rise[i]),
                .fall  (w_pin_fall[i])
            );
        end
    endgenerate

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_mosi_sync;
    logic w_cs_sync;

    assign w_sclk_rise = w_pin_rise[c_PIN_SCLK];
    assign w_sclk_fall = w_pin_fall[c_PIN_SCLK];
    assign w_mosi_sync = w_pin_sync[c_PIN_MOSI];
    assign w_cs_sync   = w_pin_sync[c_PIN_CS];

    // Strobes and control bits that this block does not use
    logic w_unused_bits;
    assign w_unused_bits = ^{w_pin_sync[c_PIN_SCLK],
                             w_pin_rise[c_PIN_MOSI], w_pin_fall[c_PIN_MOSI],
                             w_pin_rise[c_PIN_CS],   w_pin_fall[c_PIN_CS],
                             ctrl_reg[31:9], ctrl_reg[7:5]};

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       w_enable;
    logic [4:0] w_start_width;

    assign w_enable      = ctrl_reg[c_CTRL_ENABLE];
    assign w_start_width = eff_width(ctrl_reg[c_CTRL_WIDTH_MSB:c_CTRL_WIDTH_LSB]);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [4:0]  r_width;
    logic [4:0]  r_count;
    logic [31:0] r_hold;
    logic        r_loaded;
    logic [31:0] r_tx_shift;
    logic [31:0] r_rx_shift;
    logic        r_miso;
    logic [31:0] r_dout;
    logic        r_rx_valid;
    logic        r_busy;
    logic        r_overrun;
    logic        r_tx_stale;

    // The frame is complete on the rising strobe that takes the count to width
    logic w_last_rise;
    assign w_last_rise = w_sclk_rise && ((r_count + 5'd1) == r_width);

    // Bit sent on the next falling edge, indexed from the MSB of the frame
    logic [4:0] w_tx_index;
    assign w_tx_index = r_width - 5'd1 - r_count;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; losing enable overrides every other transition
    always_comb begin
        w_next_state = r_state;
        if (!w_enable) begin
            w_next_state = c_ST_OFF;
        end else begin
            case (r_state)
                c_ST_OFF:   w_next_state = c_ST_IDLE;
                c_ST_IDLE:  if (!w_cs_sync) w_next_state = c_ST_START;
                c_ST_START: w_next_state = c_ST_SHIFT;
                c_ST_SHIFT: begin
                    if (w_last_rise) begin
                        w_next_state = c_ST_DONE;
                    end else if (w_cs_sync) begin
                        w_next_state = c_ST_IDLE;
                    end
                end
                c_ST_DONE:  w_next_state = w_cs_sync ? c_ST_IDLE : c_ST_START;
                default:    w_next_state = c_ST_OFF;
            endcase
        end
    end

    // Bus-side registers plus the shift datapath; DONE is written last so it wins over ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_width    <= 5'd1;
            r_count    <= 5'd0;
            r_hold     <= 32'd0;
            r_loaded   <= 1'b0;
            r_tx_shift <= 32'd0;
            r_rx_shift <= 32'd0;
            r_miso     <= 1'b0;
            r_dout     <= 32'd0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_tx_stale <= 1'b0;
        end else begin
            if (load) begin
                r_hold <= din;
            end

            // A load coinciding with START counts toward the following frame
            if (r_state == c_ST_START) begin
                r_loaded <= load;
            end else if (load) begin
                r_loaded <= 1'b1;
            end

            if (ack) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end

            if (!w_enable) begin
                r_count <= 5'd0;
                r_miso  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_OFF: begin
                        r_count <= 5'd0;
                        r_miso  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    c_ST_START: begin
                        r_width    <= w_start_width;
                        r_tx_shift <= r_hold;
                        r_miso     <= r_hold[w_start_width - 5'd1];
                        r_rx_shift <= 32'd0;
                        r_count    <= 5'd0;
                        r_busy     <= 1'b1;
                        r_tx_stale <= ~r_loaded;
                    end
                    c_ST_SHIFT: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= {r_rx_shift[30:0], w_mosi_sync};
                            r_count    <= r_count + 5'd1;
                        end
                        if (w_sclk_fall && (r_count < r_width)) begin
                            r_miso <= r_tx_shift[w_tx_index];
                        end
                        if (w_cs_sync && !w_last_rise) begin
                            r_busy <= 1'b0;
                        end
                    end
                    c_ST_DONE: begin
                        r_dout     <= r_rx_shift & width_mask(r_width);
                        r_overrun  <= r_overrun | r_rx_valid;
                        r_rx_valid <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Status word assembly
    always_comb begin
        status_reg                  = 32'd0;
        status_reg[c_STAT_RX_VALID] = r_rx_valid;
        status_reg[c_STAT_BUSY]     = r_busy;
        status_reg[c_STAT_OVERRUN]  = r_overrun;
        status_reg[c_STAT_TX_STALE] = r_tx_stale;
    end

    assign dout = r_dout;
    assign miso = r_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_io
//  Description : Self-checking bench for spi_slave_io. The bench acts as the
//                SPI master and keeps a frame-level model of the bus registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_io;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ctrl_reg;
    logic [31:0] din;
    logic        load;
    logic        ack;
    logic [31:0] dout;
    logic [31:0] status_reg;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        miso;

    always #5 clk = ~clk;

    spi_slave_io u_dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_reg   (ctrl_reg),
        .din        (din),
        .load       (load),
        .ack        (ack),
        .dout       (dout),
        .status_reg (status_reg),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .miso       (miso)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Frame-level model of the register file
    logic [31:0] m_hold;
    logic [31:0] m_dout;
    bit          m_loaded;
    bit          m_rx_valid;
    bit          m_overrun;
    bit          m_stale;

    function automatic logic [31:0] mask_of(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic int width_of(input logic [31:0] ctrl);
        int w;
        w = int'(ctrl[4:0]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic [31:0] m_status();
        return {28'd0, m_stale, m_overrun, 1'b0, m_rx_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model whenever no frame is in flight
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("dout_vs_model", dout, m_dout);
            check("status_vs_model", status_reg, m_status());
        end
    end

    task automatic model_reset();
        m_hold     = 32'd0;
        m_dout     = 32'd0;
        m_loaded   = 1'b0;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
        m_stale    = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] v);
        @(negedge clk);
        din      = v;
        load     = 1'b1;
        m_hold   = v;
        m_loaded = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack        = 1'b1;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // One SPI mode-0 frame as master. abort_after >= 0 raises cs_n after that many bits.
    task automatic spi_frame(input logic [31:0] word, input int h, input int abort_after,
                             input bit en, input bit ack_on_done, input bit load_at_start,
                             input logic [31:0] ld_val, input bit scramble,
                             output logic [31:0] got);
        int          w;
        int          b;
        bit          full;
        logic [31:0] tx_exp;
        w    = width_of(ctrl_reg);
        full = en && !(abort_after >= 0 && abort_after < w);
        got  = 32'd0;
        @(negedge clk);
        chk_en = 1'b0;
        cs_n   = 1'b0;
        mosi   = word[w-1];
        if (en) begin
            tx_exp   = m_hold & mask_of(w);
            m_stale  = !m_loaded;
            m_loaded = 1'b0;
        end else begin
            tx_exp = 32'd0;
        end
        if (load_at_start) begin
            repeat (3) @(negedge clk);
            din      = ld_val;
            load     = 1'b1;
            m_hold   = ld_val;
            m_loaded = 1'b1;
            @(negedge clk);
            load = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        if (scramble) ctrl_reg[4:0] = 5'($urandom);
        check("busy_in_frame", {31'd0, status_reg[1]}, {31'd0, en});
        for (int i = 0; i < w; i++) begin
            b = w - 1 - i;
            if (i == abort_after) begin
                cs_n = 1'b1;
                break;
            end
            mosi = word[b];
            if (i > 0) repeat (h) @(negedge clk);
            got[b] = miso;
            sclk   = 1'b1;
            if (i == w - 1) begin
                @(negedge clk);
                cs_n = 1'b1;
                @(negedge clk);
                @(negedge clk);
                if (ack_on_done) ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                repeat (h - 4) @(negedge clk);
                sclk = 1'b0;
            end else begin
                repeat (h) @(negedge clk);
                sclk = 1'b0;
            end
        end
        repeat (8) @(negedge clk);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        if (full) begin
            m_overrun  = m_overrun | m_rx_valid;
            m_rx_valid = 1'b1;
            m_dout     = word & mask_of(w);
        end
        if (full || !en) check("miso_word", got, tx_exp);
        chk_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run, expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] rword;
        int          rw;
        int          rh;
        int          rab;

        reset    = 1'b1;
        ctrl_reg = 32'd0;
        din      = 32'd0;
        load     = 1'b0;
        ack      = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        cs_n     = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_dout", dout, 32'd0);
        check("reset_status", status_reg, 32'd0);
        check("reset_miso", {31'd0, miso}, 32'd0);
        chk_en = 1'b1;

        // Basic 8-bit exchange
        ctrl_reg = 32'h0000_0108;
        do_load(32'h0000_00A5);
        spi_frame(32'h3C, 4, -1, 1, 0, 0, 0, 0, got);
        check("t1_dout", dout, 32'h3C);
        check("t1_status", status_reg, 32'h1);
        check("t1_master_rx", got, 32'hA5);

        // Width field zero behaves as one bit
        do_ack();
        ctrl_reg = 32'h0000_0100;
        do_load(32'h1);
        spi_frame(32'h1, 5, -1, 1, 0, 0, 0, 0, got);
        check("t2_dout", dout, 32'h1);
        check("t2_master_rx", got, 32'h1);

        // Two unacknowledged frames without reload
        do_ack();
        ctrl_reg = 32'h0000_0108;
        spi_frame(32'h11, 4, -1, 1, 0, 0, 0, 0, got);
        spi_frame(32'h22, 6, -1, 1, 0, 0, 0, 0, got);
        check("t3_dout", dout, 32'h22);
        check("t3_status", status_reg, 32'hD);

        // Abort after three bits, then a full frame
        do_ack();
        do_load(32'h77);
        spi_frame(32'hFF, 4, 3, 1, 0, 0, 0, 0, got);
        check("t4_abort_status", status_reg, 32'h0);
        check("t4_abort_dout", dout, 32'h22);
        spi_frame(32'h5A, 4, -1, 1, 0, 0, 0, 0, got);
        check("t4_dout", dout, 32'h5A);
        check("t4_busy", {31'd0, status_reg[1]}, 32'd0);
        check("t4_master_rx", got, 32'h77);

        // ack on the DONE cycle of a second unacknowledged frame
        do_ack();
        spi_frame(32'h33, 4, -1, 1, 0, 0, 0, 0, got);
        spi_frame(32'h44, 4, -1, 1, 1, 0, 0, 0, got);
        check("t5_valid_overrun", {29'd0, status_reg[2:0]}, 32'h5);

        // load on the START cycle goes to the following frame
        do_load(32'hC3);
        spi_frame(32'h01, 5, -1, 1, 0, 1, 32'h3E, 0, got);
        check("t6_first_tx", got, 32'hC3);
        spi_frame(32'h02, 5, -1, 1, 0, 0, 0, 0, got);
        check("t6_second_tx", got, 32'h3E);
        check("t6_not_stale", {31'd0, status_reg[3]}, 32'd0);

        // Disabled responder ignores the bus
        ctrl_reg = 32'h0000_0008;
        spi_frame(32'h99, 4, -1, 0, 0, 0, 0, 0, got);
        check("t7_off_dout", dout, 32'h02);
        ctrl_reg = 32'h0000_0108;
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame
        chk_en = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        mosi = 1'b1;
        repeat (6) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        reset    = 1'b1;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        ctrl_reg = 32'd0;
        model_reset();
        @(negedge clk);
        check("t8_reset_dout", dout, 32'd0);
        check("t8_reset_status", status_reg, 32'd0);
        check("t8_reset_miso", {31'd0, miso}, 32'd0);
        reset    = 1'b0;
        ctrl_reg = 32'h0000_0108;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        spi_frame(32'hF0, 4, -1, 1, 0, 0, 0, 0, got);
        check("t8_dout", dout, 32'hF0);

        // Randomized frames against the model
        for (int k = 0; k < 40; k++) begin
            ctrl_reg = ($urandom & 32'hFFFF_FEE0) | 32'h100 | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) do_load($urandom);
            if ($urandom_range(0, 1) == 1) do_ack();
            rw    = width_of(ctrl_reg);
            rh    = int'($urandom_range(4, 6));
            rab   = (rw > 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, rw - 1)) : -1;
            rword = $urandom;
            spi_frame(rword, rh, rab, 1, (rab < 0) && ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 3) == 0, got);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
